// File: rtl/core_if.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding request
// against instruction memory and hands {pc, pc+4, inst} to decode.
package core_if_pkg;
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] pc4;
        logic [31:0] inst;
    } IF_regs_t;
endpackage

module core_if
    import core_if_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output IF_regs_t    IF_regs
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [63:0] pc_r;
    logic [63:0] pc_s;
    logic [31:0] hold_inst_r;
    logic [31:0] hold_inst_s;
    IF_regs_t    if_regs_r;
    IF_regs_t    if_regs_s;
    logic        deliver_s;
    logic [31:0] deliver_inst_s;

    // Sequential PC successor; wraps modulo 2^64.
    function automatic logic [63:0] pc_plus4(input logic [63:0] pc);
        return pc + 64'd4;
    endfunction

    assign imem_req  = (state_r == ST_REQ) && !redirect && !reset;
    assign imem_addr = {pc_r[63:2], 2'b00};
    assign IF_regs   = if_regs_r;

    // Next-state, next-PC and fetch-buffer selection.
    always_comb begin
        state_s        = state_r;
        pc_s           = pc_r;
        hold_inst_s    = hold_inst_r;
        deliver_s      = 1'b0;
        deliver_inst_s = 32'h0000_0000;
        case (state_r)
            ST_REQ: begin
                if (redirect) begin
                    pc_s = redirect_pc;
                end else if (imem_ready) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_s    = redirect_pc;
                    state_s = imem_rvalid ? ST_REQ : ST_DROP;
                end else if (imem_rvalid && !stall) begin
                    deliver_s      = 1'b1;
                    deliver_inst_s = imem_rdata;
                    pc_s           = pc_plus4(pc_r);
                    state_s        = ST_REQ;
                end else if (imem_rvalid) begin
                    hold_inst_s = imem_rdata;
                    state_s     = ST_HOLD;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_s    = redirect_pc;
                    state_s = ST_REQ;
                end else if (!stall) begin
                    deliver_s      = 1'b1;
                    deliver_inst_s = hold_inst_r;
                    pc_s           = pc_plus4(pc_r);
                    state_s        = ST_REQ;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DROP: begin
                // A redirect here only retargets; the stale response must still drain.
                if (redirect) begin
                    pc_s = redirect_pc;
                end else begin
                    pc_s = pc_r;
                end
                if (imem_rvalid) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_REQ;
            end
        endcase
    end

    // Output register to decode: redirect bubbles, stall holds, else deliver or bubble.
    always_comb begin
        if_regs_s = '0;
        if (redirect) begin
            if_regs_s = '0;
        end else if (stall) begin
            if_regs_s = if_regs_r;
        end else if (deliver_s) begin
            if_regs_s.pc   = pc_r;
            if_regs_s.pc4  = pc_plus4(pc_r);
            if_regs_s.inst = deliver_inst_s;
        end else begin
            if_regs_s = '0;
        end
    end

    // State, PC, fetch buffer and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_REQ;
            pc_r        <= RESET_PC;
            hold_inst_r <= 32'h0000_0000;
            if_regs_r   <= '0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            hold_inst_r <= hold_inst_s;
            if_regs_r   <= if_regs_s;
        end
    end

endmodule

// File: tb/tb_core_if.sv
// Bench for core_if: hand-built vector table for the directed corners, then
// randomized traffic against a flag-based fetch model and a latency-randomized memory.
module tb_core_if;
    import core_if_pkg::*;

    localparam logic [63:0] RPC = 64'h0000_0000_0000_0400;

    logic        clock = 1'b0;
    logic        reset, stall, redirect, imem_ready, imem_rvalid;
    logic [63:0] redirect_pc;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [63:0] imem_addr;
    IF_regs_t    IF_regs;

    core_if #(.RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_regs(IF_regs)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst, stl, rdr;
        logic [63:0] rpc;
        logic        rdy, rv;
        logic [31:0] rd;
        logic        ereq;
        logic [63:0] eaddr, epc, epc4;
        logic [31:0] einst;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: one optional outstanding request (maybe stale),
    // one optional buffered instruction, the fetch PC and the decode-facing output.
    bit          m_known = 1'b0;
    bit          m_busy, m_stale, m_bufv;
    logic [31:0] m_buf;
    logic [63:0] m_pc;
    logic [63:0] o_pc, o_pc4;
    logic [31:0] o_inst;
    bit          last_acc;

    function automatic vec_t mk(input logic rst, stl, rdr, input logic [63:0] rpc,
                                input logic rdy, rv, input logic [31:0] rd,
                                input logic ereq, input logic [63:0] eaddr, epc, epc4,
                                input logic [31:0] einst);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.rdy = rdy; v.rv = rv;
        v.rd = rd; v.ereq = ereq; v.eaddr = eaddr; v.epc = epc; v.epc4 = epc4;
        v.einst = einst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_update(input vec_t v);
        bit          dlv;
        logic [31:0] dinst;
        dlv = 1'b0;
        dinst = 32'h0;
        if (v.rst) begin
            m_pc = RPC; m_busy = 0; m_stale = 0; m_bufv = 0;
            o_pc = 64'h0; o_pc4 = 64'h0; o_inst = 32'h0;
            m_known = 1'b1;
            return;
        end
        if (m_busy && !m_stale) begin
            if (v.rv) begin
                m_busy = 0;
                if (v.rdr) m_pc = v.rpc;
                else if (!v.stl) begin dlv = 1; dinst = v.rd; end
                else begin m_bufv = 1; m_buf = v.rd; end
            end else if (v.rdr) begin
                m_stale = 1; m_pc = v.rpc;
            end
        end else if (m_busy) begin
            if (v.rv) begin m_busy = 0; m_stale = 0; end
            if (v.rdr) m_pc = v.rpc;
        end else if (m_bufv) begin
            if (v.rdr) begin m_bufv = 0; m_pc = v.rpc; end
            else if (!v.stl) begin dlv = 1; dinst = m_buf; m_bufv = 0; end
        end else begin
            if (v.rdr) m_pc = v.rpc;
            else if (v.rdy) m_busy = 1;
        end
        if (v.rdr) begin
            o_pc = 64'h0; o_pc4 = 64'h0; o_inst = 32'h0;
        end else if (v.stl) begin
            o_pc = o_pc;
        end else if (dlv) begin
            o_pc = m_pc; o_pc4 = m_pc + 64'd4; o_inst = dinst;
        end else begin
            o_pc = 64'h0; o_pc4 = 64'h0; o_inst = 32'h0;
        end
        if (dlv) m_pc = m_pc + 64'd4;
    endtask

    // One clock: drive at negedge, sample 1ns later, then advance the model at posedge.
    task automatic step(input vec_t v, input bit use_tab);
        @(negedge clock);
        reset = v.rst; stall = v.stl; redirect = v.rdr; redirect_pc = v.rpc;
        imem_ready = v.rdy; imem_rvalid = v.rv; imem_rdata = v.rd;
        #1;
        last_acc = imem_req && imem_ready;
        if (m_known) begin
            chk("model_req", {63'h0, imem_req},
                {63'h0, (!m_busy && !m_bufv && !v.rdr && !v.rst)});
            chk("model_addr", imem_addr, {m_pc[63:2], 2'b00});
            chk("model_pc", IF_regs.pc, o_pc);
            chk("model_pc4", IF_regs.pc4, o_pc4);
            chk("model_inst", {32'h0, IF_regs.inst}, {32'h0, o_inst});
        end
        if (use_tab) begin
            chk("tab_req", {63'h0, imem_req}, {63'h0, v.ereq});
            chk("tab_addr", imem_addr, v.eaddr);
            chk("tab_pc", IF_regs.pc, v.epc);
            chk("tab_pc4", IF_regs.pc4, v.epc4);
            chk("tab_inst", {32'h0, IF_regs.inst}, {32'h0, v.einst});
        end
        @(posedge clock);
        model_update(v);
    endtask

    localparam logic [63:0] Z  = 64'h0;
    localparam logic [63:0] TP = 64'h0000_0000_8000_0180;
    localparam logic [63:0] TW = 64'hFFFF_FFFF_FFFF_FFFC;

    vec_t tab [25];
    vec_t rv_v;
    int   mem_cnt;

    initial begin
        tab[0]  = mk(1'b1,1'b0,1'b0,Z,1'b0,1'b0,32'h0,        1'b0,64'h400,Z,Z,32'h0);
        tab[1]  = mk(1'b0,1'b0,1'b0,Z,1'b1,1'b0,32'h0,        1'b1,64'h400,Z,Z,32'h0);
        tab[2]  = mk(1'b0,1'b0,1'b0,Z,1'b0,1'b1,32'h2402_0005,1'b0,64'h400,Z,Z,32'h0);
        tab[3]  = mk(1'b0,1'b0,1'b0,Z,1'b1,1'b0,32'h0,        1'b1,64'h404,64'h400,64'h404,32'h2402_0005);
        tab[4]  = mk(1'b0,1'b0,1'b0,Z,1'b0,1'b1,32'h1111_1111,1'b0,64'h404,Z,Z,32'h0);
        tab[5]  = mk(1'b0,1'b0,1'b0,Z,1'b1,1'b0,32'h0,        1'b1,64'h408,64'h404,64'h408,32'h1111_1111);
        tab[6]  = mk(1'b0,1'b1,1'b0,Z,1'b0,1'b1,32'hDEAD_BEEF,1'b0,64'h408,Z,Z,32'h0);
        tab[7]  = mk(1'b0,1'b1,1'b0,Z,1'b1,1'b0,32'h0,        1'b0,64'h408,Z,Z,32'h0);
        tab[8]  = mk(1'b0,1'b1,1'b0,Z,1'b1,1'b0,32'h0,        1'b0,64'h408,Z,Z,32'h0);
        tab[9]  = mk(1'b0,1'b0,1'b0,Z,1'b0,1'b0,32'h0,        1'b0,64'h408,Z,Z,32'h0);
        tab[10] = mk(1'b0,1'b0,1'b0,Z,1'b0,1'b0,32'h0,        1'b1,64'h40C,64'h408,64'h40C,32'hDEAD_BEEF);
        tab[11] = mk(1'b0,1'b0,1'b0,Z,1'b1,1'b0,32'h0,        1'b1,64'h40C,Z,Z,32'h0);
        tab[12] = mk(1'b0,1'b0,1'b1,TP,1'b0,1'b0,32'h0,       1'b0,64'h40C,Z,Z,32'h0);
        tab[13] = mk(1'b0,1'b0,1'b0,Z,1'b0,1'b0,32'h0,        1'b0,TP,Z,Z,32'h0);
        tab[14] = mk(1'b0,1'b0,1'b0,Z,1'b0,1'b1,32'h0BAD_F00D,1'b0,TP,Z,Z,32'h0);
        tab[15] = mk(1'b0,1'b0,1'b0,Z,1'b1,1'b0,32'h0,        1'b1,TP,Z,Z,32'h0);
        tab[16] = mk(1'b0,1'b0,1'b0,Z,1'b0,1'b1,32'h3C01_0001,1'b0,TP,Z,Z,32'h0);
        tab[17] = mk(1'b0,1'b1,1'b1,TW,1'b1,1'b0,32'h0,       1'b0,64'h8000_0184,TP,64'h8000_0184,32'h3C01_0001);
        tab[18] = mk(1'b0,1'b0,1'b0,Z,1'b1,1'b0,32'h0,        1'b1,TW,Z,Z,32'h0);
        tab[19] = mk(1'b0,1'b0,1'b0,Z,1'b0,1'b1,32'h0000_000C,1'b0,TW,Z,Z,32'h0);
        tab[20] = mk(1'b0,1'b0,1'b0,Z,1'b0,1'b0,32'h0,        1'b1,Z,TW,Z,32'h0000_000C);
        tab[21] = mk(1'b0,1'b0,1'b0,Z,1'b0,1'b1,32'h7777_7777,1'b1,Z,Z,Z,32'h0);
        tab[22] = mk(1'b0,1'b0,1'b0,Z,1'b1,1'b0,32'h0,        1'b1,Z,Z,Z,32'h0);
        tab[23] = mk(1'b1,1'b0,1'b0,Z,1'b0,1'b0,32'h0,        1'b0,Z,Z,Z,32'h0);
        tab[24] = mk(1'b0,1'b0,1'b0,Z,1'b0,1'b0,32'h0,        1'b1,64'h400,Z,Z,32'h0);

        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        step(tab[0], 1'b0);
        for (int i = 0; i < 25; i++) step(tab[i], 1'b1);

        // Random traffic: memory answers each accepted request after 1..3 cycles.
        mem_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            rv_v = mk(1'b0,1'b0,1'b0,Z,1'b0,1'b0,32'h0,1'b0,Z,Z,Z,32'h0);
            rv_v.rst = ($urandom_range(0, 99) == 0);
            rv_v.stl = ($urandom_range(0, 3) == 0);
            rv_v.rdr = ($urandom_range(0, 7) == 0);
            rv_v.rpc = ($urandom_range(0, 3) == 0) ? TW : {$urandom, $urandom};
            rv_v.rdy = ($urandom_range(0, 2) != 0);
            rv_v.rd  = $urandom;
            if (mem_cnt > 0) begin
                mem_cnt--;
                rv_v.rv = (mem_cnt == 0);
            end else begin
                rv_v.rv = ($urandom_range(0, 15) == 0);
            end
            step(rv_v, 1'b0);
            if (rv_v.rst) mem_cnt = 0;
            else if (last_acc) mem_cnt = $urandom_range(1, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/core_if.md
Name: core_if

Overview:
- Instruction-fetch stage of the 64-bit MIPS pipeline; sits directly upstream of the decode stage and produces `IF_regs` (`IF_regs_t`: `pc[63:0]`, `pc4[63:0]`, `inst[31:0]`).
- Owns the PC register and drives a variable-latency instruction memory port with one outstanding request.
- Holds its output while decode is stalled; bubbles when no instruction is available.
- Accepts PC redirects (branch, jump, exception, ERET), already priority-resolved by the hazard/control logic.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC loaded on reset.

Ports:
- clock  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  decode cannot accept; hold `IF_regs` and PC.
- redirect  input  1  discard in-flight fetch; continue at `redirect_pc`.
- redirect_pc  input  64  new fetch address.
- imem_req  output  1  request valid.
- imem_addr  output  64  request address, word aligned.
- imem_ready  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  fetched instruction.
- IF_regs  output  IF_regs_t  registered fetch result to decode.

Behaviour:
- Clock and reset: one clock (`clock`); reset (`reset`) is synchronous and active-high. All state updates on posedge `clock`.
- Reset: pc=RESET_PC, state=REQ, hold_inst=0, `IF_regs`='0. `imem_req` is 0 on the cycle reset is high.
- Reset mid-operation: any outstanding response after reset is ignored until the next REQ handshake. The memory is reset together with this block, so no late response arrives.
- States:
  - REQ: issue fetch.
  - WAIT: request accepted, awaiting data.
  - HOLD: data received while stalled, buffered.
  - DROP: awaiting a stale response to discard.
- `imem_req` = (state==REQ) && !redirect && !reset. `imem_addr` = {pc[63:2],2'b00}; pc[1:0] is ignored.
- REQ:
  - redirect: pc<=redirect_pc, stay REQ.
  - else if `imem_ready`: go WAIT.
  - else stay REQ.
- WAIT:
  - redirect & `imem_rvalid`: discard data, pc<=redirect_pc, go REQ.
  - redirect & !`imem_rvalid`: pc<=redirect_pc, go DROP.
  - `imem_rvalid` & !stall: `IF_regs`<={pc, pc+4, imem_rdata}, pc<=pc+4, go REQ.
  - `imem_rvalid` & stall: hold_inst<=imem_rdata, go HOLD.
- HOLD:
  - redirect: discard buffer, pc<=redirect_pc, go REQ.
  - !stall: `IF_regs`<={pc, pc+4, hold_inst}, pc<=pc+4, go REQ.
  - else stay HOLD.
- DROP:
  - `imem_rvalid`: discard, go REQ.
  - redirect in DROP: pc<=redirect_pc, stay DROP.
- `IF_regs` update priority (highest first):
  1. reset → '0.
  2. redirect → '0 (bubble; redirect overrides stall).
  3. stall → hold previous value.
  4. delivery as above.
  5. otherwise → '0 (bubble; inst=0 is NOP).
- Arithmetic: pc4 = pc + 64'd4, modulo 2^64 (wraps to 0 from 64'hFFFF_FFFF_FFFF_FFFC).
- Latency: with `imem_ready`=1 and 1-cycle response, each instruction takes 2 cycles. REQ cycle N, rvalid N+1, `IF_regs` valid from N+2, next REQ at N+2. Throughput is one instruction every 2 cycles (one outstanding request).
- Never more than one accepted, unanswered request. `imem_req` stays low outside REQ.
- `imem_rvalid` outside WAIT/DROP is a protocol error, ignored; asserting it is required in the bench.

Test Plan:
- Reset with RESET_PC=64'h400:
  - first cycle after reset: `imem_req`=1, `imem_addr`=64'h400.
  - `IF_regs`='0 until rdata 32'h2402_0005 returns.
  - then `IF_regs`={64'h400, 64'h404, 32'h2402_0005}.
- Three back-to-back fetches, ready=1, 1-cycle latency:
  - `imem_addr` sequence 64'h400, 64'h404, 64'h408, each 2 cycles apart.
  - bubble ('0) between deliveries.
- stall high when rvalid arrives with 32'hDEAD_BEEF, stall held 3 cycles:
  - `IF_regs` unchanged, `imem_req`=0 throughout.
  - after stall drops, `IF_regs`.inst=32'hDEAD_BEEF next cycle, pc advances by 4.
- redirect to 64'h8000_0180 while in WAIT, rvalid 2 cycles later:
  - returned data never appears in `IF_regs`.
  - next `imem_addr`=64'h8000_0180.
- redirect and stall asserted together with `IF_regs` valid:
  - `IF_regs`='0 next cycle (redirect wins).
  - subsequent fetch at `redirect_pc`.
- redirect_pc=64'hFFFF_FFFF_FFFF_FFFC:
  - delivered `IF_regs`.pc4=64'h0.
  - next `imem_addr`=64'h0.
- Additional check: reset asserted in WAIT → state REQ, `IF_regs`='0, pc=RESET_PC next cycle.
